// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared definitions for the sequenced magnitude comparator:
//   - state_e      : controller states (IDLE, SCAN, DONE)
//   - SLICE_BITS   : operand bits examined per SCAN cycle
//   - clog2()      : ceiling log2, used to size the index and scan counter
// Optional build macro used by the controller: SERIAL_CMP_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

   localparam int SLICE_BITS = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_ctrl_cmp2_slice.sv
// -----------------------------------------------------------------------------
// cmp2_slice
// Purely combinational 2-bit unsigned magnitude comparator. Exactly one of
// gt_o / lt_o / eq_o is high for any input pair.
// Ports:
//   a_i  [1:0]  operand A slice
//   b_i  [1:0]  operand B slice
//   gt_o        a_i >  b_i
//   lt_o        a_i <  b_i
//   eq_o        a_i == b_i
// -----------------------------------------------------------------------------
module cmp2_slice
   import serial_cmp_pkg::*;
(
   input  logic [SLICE_BITS-1:0] a_i,
   input  logic [SLICE_BITS-1:0] b_i,
   output logic                  gt_o,
   output logic                  lt_o,
   output logic                  eq_o
);

   always_comb begin
      gt_o = (a_i > b_i);
      lt_o = (a_i < b_i);
      eq_o = (a_i == b_i);
   end

endmodule : cmp2_slice

// File: rtl/serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_cmp_ctrl
// Sequenced WIDTH-bit unsigned magnitude comparator. A single 2-bit slice
// comparator is time-shared, scanning the captured operands MSB-first, one
// slice per cycle. Results are registered and held until the next accept.
//
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave SCAN as soon as a
// slice differs; otherwise every slice is always scanned (fixed latency).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request, accepted only while ready=1
//   a_in      operand A, captured on the accept edge
//   b_in      operand B, captured on the accept edge
//   ready     high only in IDLE
//   done      one-cycle pulse (DONE state) when the result becomes valid
//   a_gt_b    registered result A > B
//   a_lt_b    registered result A < B
//   a_eq_b    registered result A == B
//   scan_cnt  number of slices examined by the last operation
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1. start while ready=0 has no effect and the operands are not
// sampled. done is asserted for exactly one cycle per accepted operation
// unless rst intervenes.
//
// WIDTH must be even and >= 2.
// -----------------------------------------------------------------------------
module serial_cmp_ctrl
   import serial_cmp_pkg::*;
#(
   parameter  int WIDTH  = 8,
   localparam int NSLICE = WIDTH / 2,
   localparam int CNT_W  = clog2(NSLICE + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b,
   output logic [CNT_W-1:0] scan_cnt
);

   // Index needs at least one bit even for a single-slice build.
   localparam int IDX_W = (NSLICE > 1) ? clog2(NSLICE) : 1;

   // Plain vector encodings of the state enum.
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_SCAN = ST_SCAN;
   localparam logic [1:0] S_DONE = ST_DONE;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Current slice selected by idx_q.
   logic [SLICE_BITS-1:0] a_slice;
   logic [SLICE_BITS-1:0] b_slice;
   logic                  s_gt;
   logic                  s_lt;
   logic                  s_eq;
   logic                  last_slice;

   always_comb begin
      a_slice = a_q[idx_q*SLICE_BITS +: SLICE_BITS];
      b_slice = b_q[idx_q*SLICE_BITS +: SLICE_BITS];
   end

   cmp2_slice u_slice (
      .a_i  (a_slice),
      .b_i  (b_slice),
      .gt_o (s_gt),
      .lt_o (s_lt),
      .eq_o (s_eq)
   );

   // SCAN ends on the LSB slice; with early exit it also ends on the first
   // differing slice. Once a slice differs the sticky flags are already set,
   // so the remaining slices cannot change the outcome either way.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   always_comb last_slice = (idx_q == '0) || !s_eq;
`else
   always_comb last_slice = (idx_q == '0);
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               idx_d   = IDX_W'(NSLICE - 1);
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_SCAN;
            end
         end

         S_SCAN: begin
            cnt_d = cnt_q + 1'b1;
            // Only the most significant differing slice decides the result.
            if (!gt_q && !lt_q && !s_eq) begin
               gt_d = s_gt;
               lt_d = s_lt;
            end
            if (last_slice) begin
               eq_d    = !gt_d && !lt_d;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         cnt_q   <= cnt_d;
      end
   end

   // The slice counter stops in DONE and is held through IDLE, so it directly
   // reports the slices examined by the last operation.
   always_comb begin
      ready    = (state_q == S_IDLE);
      done     = (state_q == S_DONE);
      a_gt_b   = gt_q;
      a_lt_b   = lt_q;
      a_eq_b   = eq_q;
      scan_cnt = cnt_q;
   end

endmodule : serial_cmp_ctrl

// File: tb/tb_serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_cmp_ctrl
// Scoreboard bench for serial_cmp_ctrl (WIDTH=8). The driver pushes the
// expected result of every accepted operation into exp_q; a monitor pops and
// compares on each done pulse. Expected results come from plain arithmetic
// comparison and the position of the highest differing bit.
// -----------------------------------------------------------------------------
module tb_serial_cmp_ctrl;

   localparam int WIDTH  = 8;
   localparam int NSLICE = WIDTH / 2;
   localparam int CNT_W  = 3;
   // Expected entry: {gt, lt, eq, scan_cnt, accept cycle}
   localparam int EW     = 3 + CNT_W + 32;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             done;
   logic             a_gt_b;
   logic             a_lt_b;
   logic             a_eq_b;
   logic [CNT_W-1:0] scan_cnt;

   serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .ready    (ready),
      .done     (done),
      .a_gt_b   (a_gt_b),
      .a_lt_b   (a_lt_b),
      .a_eq_b   (a_eq_b),
      .scan_cnt (scan_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [EW-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input int unsigned c0);
      logic [WIDTH-1:0] diff;
      int               top;
      int               k;
      logic             gt, lt, eq;
      gt   = (a > b);
      lt   = (a < b);
      eq   = (a == b);
      diff = a ^ b;
      top  = -1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (diff[i] && top < 0) top = i;
      end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      // Leading equal slices plus the deciding slice.
      k = (top < 0) ? NSLICE : NSLICE - top / 2;
`else
      k = NSLICE;
`endif
      return {gt, lt, eq, CNT_W'(k), c0};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [EW-1:0] e;
            int unsigned   k;
            e = exp_q.pop_front();
            k = 32'(e[32 +: CNT_W]);
            check("flags",    {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, e[EW-1 -: 3]});
            check("scan_cnt", 32'(scan_cnt), k);
            check("latency",  cyc - e[31:0], k + 1);
            check("onehot",   32'($countones({a_gt_b, a_lt_b, a_eq_b})), 32'd1);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_ready();
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   // Presents one operation at a negedge where ready=1 (accepted on the next
   // rising edge). With hold=1, start stays high for back-to-back operation.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
      wait_ready();
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      exp_q.push_back(model(a, b, cyc));
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned c0;
      bit          seen_done;
      logic [WIDTH-1:0] ra, rb;

      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready",  32'(ready), 32'd1);
      check("rst_done",   32'(done), 32'd0);
      check("rst_flags",  {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
      check("rst_cnt",    32'(scan_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed operations
      issue(8'h5A, 8'h5A, 1'b0);
      issue(8'h80, 8'h7F, 1'b0);
      issue(8'h02, 8'h03, 1'b0);
      drain();

      // start pulses during an operation must be ignored
      wait_ready();
      c0 = cyc;
      issue(8'h5A, 8'h5A, 1'b0);          // now at cycle c0+1
      @(negedge clk);                      // c0+2
      a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
      @(negedge clk);                      // c0+3
      @(negedge clk);                      // c0+4
      start = 1'b0;
      @(negedge clk);                      // c0+5
      check("busy_ready5", 32'(ready), 32'd0);
      check("done_cycle5", 32'(done),  32'd1);
      @(negedge clk);                      // c0+6
      check("ready6", 32'(ready), 32'd1);
      @(negedge clk);                      // c0+7, result held in IDLE
      check("hold_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd1);
      check("hold_cnt",   32'(scan_cnt), 32'd4);
      check("cycle_check", cyc - c0, 32'd7);

      // Reset in the middle of SCAN
      wait_ready();
      c0 = cyc;
      issue(8'h5A, 8'h5B, 1'b0);          // c0+1
      @(negedge clk);                      // c0+2
      rst = 1'b1;
      @(negedge clk);                      // c0+3
      void'(exp_q.pop_back());
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
      check("midrst_cnt",   32'(scan_cnt), 32'd0);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);

      // Corners and randomized back-to-back with start held high
      issue(8'h00, 8'h00, 1'b1);
      issue(8'hFF, 8'hFF, 1'b1);
      issue(8'h00, 8'hFF, 1'b1);
      issue(8'hFF, 8'h00, 1'b1);
      for (int i = 0; i < 1500; i++) begin
         ra = WIDTH'($urandom_range(0, 255));
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            default: rb = WIDTH'($urandom_range(0, 255));
         endcase
         issue(ra, rb, 1'b1);
      end
      start = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

endmodule : tb_serial_cmp_ctrl
